// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: 8x8 tile pixel generator with hblank line prefetch into a ping-pong buffer and a 16-entry palette
`ifndef VGA_MAX_Y
`define VGA_MAX_Y 525
`endif
module vga_tile_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int TILES_X = 80
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [12:0] map_addr,
  input  logic [7:0]  map_data,
  output logic [10:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        fill_busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [9:0] prev_x, next_line;
  logic [8:0] fill_line;
  logic [6:0] k, s1_k, s2_k;
  logic s1_v, s2_v, trig;
  logic [31:0] lbuf [2][TILES_X];
  logic [11:0] pal [16];
  logic [31:0] word;
  logic [3:0] nib;
  assign next_line = (DrawY == 10'(`VGA_MAX_Y - 1)) ? 10'd0 : DrawY + 10'd1;
  assign trig = DrawX == 10'(H_ACTIVE) && prev_x != 10'(H_ACTIVE) && next_line < 10'(V_ACTIVE);
  assign fill_busy = state != IDLE;
  assign map_addr = state == FETCH ? 13'(fill_line[8:3]) * 13'(TILES_X) + 13'(k) : 13'd0;
  assign rom_addr = s1_v ? {map_data, fill_line[2:0]} : 11'd0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (trig ? FETCH : IDLE) :
              state == FETCH ? (k == 7'(TILES_X - 1) ? DRAIN : FETCH) :
                               (k == 7'(TILES_X + 1) ? IDLE : DRAIN);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // k runs 0..81 across FETCH+DRAIN; the two pipeline stages carry their own word index
  always_ff @(posedge clk)
    if (reset) begin
      prev_x <= '0;
      fill_line <= '0;
      k <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_k <= '0;
      s2_k <= '0;
    end else begin
      prev_x <= DrawX;
      if (state == IDLE && trig) fill_line <= next_line[8:0];
      k <= (state == IDLE || state_n == IDLE) ? 7'd0 : k + 7'd1;
      s1_v <= state == FETCH;
      s1_k <= k;
      s2_v <= s1_v;
      s2_k <= s1_k;
    end
  always_ff @(posedge clk)
    if (s2_v) lbuf[fill_line[0]][s2_k] <= rom_data;
  assign word = lbuf[DrawY[0]][DrawX < 10'(H_ACTIVE) ? DrawX[9:3] : 7'd0];
  assign nib = word[{DrawX[2:0], 2'b00} +: 4];
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
      {red, green, blue} <= 12'd0;
    end else begin
      if (pal_we) pal[pal_addr] <= pal_data;
      {red, green, blue} <= (DrawX < 10'(H_ACTIVE) && DrawY < 10'(V_ACTIVE)) ? pal[nib] : 12'd0;
    end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: randomized checks of prefetch addressing, pixel output and palette against a tile-level model
module tb_vga_tile_renderer;
  localparam int MAX_Y = 525;
  logic clk = 1'b0, reset;
  logic [9:0] DrawX, DrawY;
  logic [12:0] map_addr;
  logic [7:0] map_data;
  logic [10:0] rom_addr;
  logic [31:0] rom_data;
  logic pal_we;
  logic [3:0] pal_addr;
  logic [11:0] pal_data;
  logic [3:0] red, green, blue;
  logic fill_busy;
  logic [7:0] map_ram [8192];
  logic [31:0] tile_rom [2048];
  logic [11:0] pal_m [16];
  int checks = 0, fails = 0;

  vga_tile_renderer dut (.clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .map_addr(map_addr), .map_data(map_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .red(red), .green(green), .blue(blue), .fill_busy(fill_busy));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    map_data <= map_ram[map_addr];
    rom_data <= tile_rom[rom_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_pix(input int y, input int x);
    int t;
    t = map_ram[(y / 8) * 80 + x / 8];
    return pal_m[(tile_rom[t * 8 + y % 8] >> (4 * (x % 8))) & 32'hF];
  endfunction

  task automatic pal_gray();
    for (int i = 0; i < 16; i++) pal_m[i] = {3{4'(i)}};
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 4800; i++) map_ram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) tile_rom[i] = $urandom;
  endtask

  task automatic do_fill(input int y);
    int nl, base, cnt;
    logic [10:0] exp_ra;
    nl = (y == MAX_Y - 1) ? 0 : y + 1;
    base = (nl / 8) * 80;
    DrawY = 10'(y); DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    if (nl < 480) begin
      for (int c = 0; c < 82; c++) begin
        checks++;
        if (fill_busy !== 1'b1) begin fails++; $display("FAIL fill_busy y=%0d c=%0d got %b want 1", y, c, fill_busy); end
        if (c < 80) begin
          checks++;
          if (map_addr !== 13'(base + c)) begin fails++; $display("FAIL map_addr y=%0d c=%0d got %0d want %0d", y, c, map_addr, base + c); end
        end
        if (c >= 1 && c <= 80) begin
          exp_ra = {map_ram[base + c - 1], 3'(nl % 8)};
          checks++;
          if (rom_addr !== exp_ra) begin fails++; $display("FAIL rom_addr y=%0d c=%0d got %h want %h", y, c, rom_addr, exp_ra); end
        end
        tick();
      end
      checks++;
      if (fill_busy !== 1'b0) begin fails++; $display("FAIL fill_end y=%0d got %b want 0", y, fill_busy); end
    end else begin
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
        if (fill_busy !== 1'b0) cnt++;
        tick();
      end
      checks++;
      if (cnt != 0) begin fails++; $display("FAIL no_fill y=%0d busy_cycles got %0d want 0", y, cnt); end
    end
  endtask

  task automatic check_line(input int y, input int n);
    int x;
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 639);
      DrawY = 10'(y); DrawX = 10'(x); tick();
      e = exp_pix(y, x);
      checks++;
      if ({red, green, blue} !== e) begin fails++; $display("FAIL pixel y=%0d x=%0d got %h want %h", y, x, {red, green, blue}, e); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; DrawX = '0; DrawY = '0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    pal_gray();
    tick();
    checks++;
    if ({red, green, blue} !== 12'd0) begin fails++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
    checks++;
    if (fill_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", fill_busy); end
    checks++;
    if (map_addr !== 13'd0 || rom_addr !== 11'd0) begin fails++; $display("FAIL reset_addr got %0d/%0d want 0/0", map_addr, rom_addr); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame_start_fill();
    randomize_mem();
    do_fill(524);
    check_line(0, 48);
  endtask

  task automatic test_row_addressing();
    do_fill(7);
    do_fill(8);
    check_line(8, 24);
    check_line(9, 24);
    do_fill(478);
    check_line(479, 24);
    do_fill(479);
    do_fill(523);
  endtask

  task automatic test_display();
    for (int i = 0; i < 4800; i++) map_ram[i] = 8'd5;
    tile_rom[40] = 32'h76543210;
    do_fill(524);
    DrawY = 10'd0; DrawX = 10'd3; tick();
    checks++;
    if ({red, green, blue} !== 12'h333) begin fails++; $display("FAIL disp_x3 got %h want 333", {red, green, blue}); end
    DrawX = 10'd700; tick();
    checks++;
    if ({red, green, blue} !== 12'h000) begin fails++; $display("FAIL disp_x700 got %h want 000", {red, green, blue}); end
    DrawY = 10'd500; DrawX = 10'd3; tick();
    checks++;
    if ({red, green, blue} !== 12'h000) begin fails++; $display("FAIL disp_vblank got %h want 000", {red, green, blue}); end
  endtask

  task automatic test_palette_write();
    DrawY = 10'd0; DrawX = 10'd2;
    pal_we = 1'b1; pal_addr = 4'd2; pal_data = 12'hF00; tick();
    pal_we = 1'b0;
    checks++;
    if ({red, green, blue} !== 12'h222) begin fails++; $display("FAIL pal_same_clk got %h want 222", {red, green, blue}); end
    pal_m[2] = 12'hF00;
    tick();
    checks++;
    if ({red, green, blue} !== 12'hF00) begin fails++; $display("FAIL pal_new got %h want F00", {red, green, blue}); end
    DrawX = 10'd3; tick();
    checks++;
    if ({red, green, blue} !== 12'h333) begin fails++; $display("FAIL pal_other got %h want 333", {red, green, blue}); end
  endtask

  task automatic test_palette_random();
    randomize_mem();
    do_fill(524);
    for (int i = 0; i < 8; i++) begin
      pal_addr = 4'($urandom); pal_data = 12'($urandom); pal_we = 1'b1; tick();
      pal_m[pal_addr] = pal_data;
    end
    pal_we = 1'b0;
    check_line(0, 48);
  endtask

  task automatic test_reset_mid_fill();
    int cnt;
    randomize_mem();
    DrawY = 10'd524; DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    for (int c = 0; c < 40; c++) tick();
    checks++;
    if (map_addr !== 13'd40) begin fails++; $display("FAIL midfill_pos got %0d want 40", map_addr); end
    reset = 1'b1; DrawX = 10'd641; tick();
    reset = 1'b0;
    pal_gray();
    checks++;
    if (fill_busy !== 1'b0 || map_addr !== 13'd0) begin fails++; $display("FAIL midfill_reset busy=%b addr=%0d want 0/0", fill_busy, map_addr); end
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (fill_busy !== 1'b0 || map_addr !== 13'd0) cnt++;
      tick();
    end
    checks++;
    if (cnt != 0) begin fails++; $display("FAIL midfill_quiet active_cycles got %0d want 0", cnt); end
    do_fill(524);
    check_line(0, 64);
  endtask

  task automatic test_back_to_back();
    int cnt;
    randomize_mem();
    do_fill(100);
    do_fill(101);
    check_line(101, 32);
    check_line(102, 32);
    DrawY = 10'd200; DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    cnt = 0;
    while (fill_busy === 1'b1 && cnt < 300) begin
      cnt++;
      if (cnt == 10) DrawX = 10'd639;
      if (cnt == 11) DrawX = 10'd640;
      tick();
    end
    checks++;
    if (cnt != 82) begin fails++; $display("FAIL retrigger_len got %0d want 82", cnt); end
    check_line(201, 32);
  endtask

  initial begin
    test_reset();
    test_frame_start_fill();
    test_row_addressing();
    test_display();
    test_palette_write();
    test_palette_random();
    test_reset_mid_fill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_tile_renderer.md
# vga_tile_renderer

Pixel-generation stage directly downstream of the VGA timing controller. It consumes `DrawX`/`DrawY` and produces 4-bit-per-channel RGB for an 80x60 grid of 8x8 tiles. During the horizontal blanking of each line it prefetches the next line from an external tile-map RAM and tile ROM into a ping-pong line buffer. During the active region it streams pixels through a 16-entry writable palette.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `TILES_X`, 80: tiles per row, equal to `H_ACTIVE`/8.
- Line count per frame is `` `VGA_MAX_Y `` from `utils.sv`.

- `clk` input 1: system clock, 2x the pixel rate. Each `DrawX` value is held for 2 clk.
- `reset` input 1: synchronous, active-high.
- `DrawX` input 10: current pixel column, from the timing controller.
- `DrawY` input 10: current line, from the timing controller.
- `map_addr` output 13: tile-map RAM address.
- `map_data` input 8: tile index. Synchronous read, valid 1 clk after `map_addr`.
- `rom_addr` output 11: tile ROM address, `{tile[7:0], row[2:0]}`.
- `rom_data` input 32: one tile row of eight 4-bit palette indices, pixel 0 in [3:0]. Valid 1 clk after `rom_addr`.
- `pal_we` input 1: palette write enable.
- `pal_addr` input 4: palette entry.
- `pal_data` input 12: `{R,G,B}` value to write.
- `red`, `green`, `blue` output 4 each: pixel colour.
- `fill_busy` output 1: high while a line prefetch is in progress.

## Operation
- Line buffer: 2 banks x 80 words x 32 bits.
  - Display bank = `DrawY[0]`.
  - `next_line` = 0 when `DrawY` = `` `VGA_MAX_Y ``-1, else `DrawY`+1.
  - Fill bank = `next_line[0]`.
- Trigger: a registered `prev_x` holds last clk's `DrawX`. Trigger fires for one clk when `DrawX` == `H_ACTIVE` and `prev_x` != `H_ACTIVE`, and only if `next_line` < `V_ACTIVE`.
- Fill FSM states:
  - IDLE: on trigger, latch `next_line` into `fill_line` and k=0, go to FETCH. Triggers in any other state are ignored.
  - FETCH, 80 clk: drive `map_addr` = `fill_line[8:3]`*80 + k, increment k. After k=79, go to DRAIN.
  - Pipeline stage 1, active 1 clk after each FETCH clk: `rom_addr` = `{map_data, fill_line[2:0]}`.
  - Pipeline stage 2, active 2 clk after each FETCH clk: write `rom_data` into fill bank word k-2.
  - DRAIN, 2 clk: completes the last two pipeline stages, then return to IDLE.
- `fill_busy` = 1 in FETCH and DRAIN. A fill takes exactly 82 clk, which fits well inside the 320-clk hblank.
- Pixel path:
  - Word = display bank[`DrawX[9:3]`], nibble = `DrawX[2:0]`, then palette lookup.
  - Output is registered. It is forced to 0 when `DrawX` >= `H_ACTIVE` or `DrawY` >= `V_ACTIVE`.
- Palette:
  - Reset value of entry i is `{i,i,i}` (grayscale).
  - A write takes effect for pixel lookups from the next clk.
  - A write and a read of the same entry in the same clk returns the old value.
- Line buffer contents are not cleared by reset.

## Timing
- Reset values: `red`/`green`/`blue` = 0, `fill_busy` = 0, `map_addr` = 0, `rom_addr` = 0, FSM = IDLE, `prev_x` = 0, palette = grayscale.
- Pixel latency: RGB reflects the `DrawX`/`DrawY` sampled on the previous clk edge, i.e. 1 clk.
- Fill timing:
  - First `map_addr` is driven on the clk after the trigger clk.
  - `fill_busy` rises the same clk as the first `map_addr` and falls 82 clk later.
- Wrap-around: on line `` `VGA_MAX_Y ``-1 the fill targets line 0, bank 0.
- Lines `V_ACTIVE`-1 through `` `VGA_MAX_Y ``-2 trigger no fill.
- Reset mid-fill: the FSM returns to IDLE on the next clk. No further line-buffer writes occur, and the partially written bank stays as-is. The next valid trigger refills the line completely.
- No write is ever made to the display bank of an active line.

## Test plan
- Reset: hold `reset` 3 clk → RGB=0, `fill_busy`=0, `map_addr`=0 on the clk after reset is asserted.
- Frame-start fill:
  - Stimulus: `DrawY`=524, `DrawX` stepping 639→640.
  - Required: `map_addr` = 0,1,…,79 on consecutive clks; `rom_addr` = `{map_data,3'd0}` one clk after each; `fill_busy` high for exactly 82 clk.
- Row addressing:
  - `DrawY`=7 hblank → `map_addr` 80..159, `rom_addr` row bits = 0.
  - `DrawY`=8 → `map_addr` 80..159, row bits = 1.
  - `DrawY`=479 → no `fill_busy`.
- Display:
  - Setup: all map entries = 5, tile 5 row 0 = `32'h76543210`, palette at reset.
  - Stimulus: line 0, `DrawX`=3.
  - Required: RGB = 3,3,3 one clk later; `DrawX`=700 → RGB = 0.
- Palette write: write entry 2 = `12'hF00` during line 0 → pixel `DrawX`=2 gives red=F, green=0, blue=0; pixel 3 is unchanged.
- Reset mid-fill: assert `reset` on FETCH clk 40 → `fill_busy`=0 the next clk and no further `map_addr` sweep. The next trigger performs a full 82-clk fill and correct pixels follow.
